// File: rtl/imm_gen_pipe_pkg.sv
// Shared types and defaults for the ID-stage immediate generator.
package imm_gen_pipe_pkg;

    localparam int DEF_FETCH_WIDTH  = 2;
    localparam int DEF_IMM_WIDTH    = 32;
    localparam int DEF_OPCODE_WIDTH = 7;
    localparam int INSTR_WIDTH      = 32;
    localparam int IMM_TYPE_WIDTH   = 3;

    typedef enum logic [2:0] {
        IMM_R   = 3'd0,
        IMM_I   = 3'd1,
        IMM_S   = 3'd2,
        IMM_B   = 3'd3,
        IMM_U   = 3'd4,
        IMM_J   = 3'd5,
        IMM_ILL = 3'd6
    } imm_type_t;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_IMM    = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_OP     = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111
    } opcode_t;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Bundle handshake between fetch queue, immediate generator and rename.
interface imm_gen_pipe_if
    import imm_gen_pipe_pkg::*;
#(
    parameter int FETCH_WIDTH = DEF_FETCH_WIDTH,
    parameter int IMM_WIDTH   = DEF_IMM_WIDTH
);

    logic                                in_valid;
    logic                                in_ready;
    logic [FETCH_WIDTH-1:0]              in_lane_vld;
    logic [FETCH_WIDTH*INSTR_WIDTH-1:0]  in_instr;

    logic                                out_valid;
    logic                                out_ready;
    logic [FETCH_WIDTH-1:0]              out_lane_vld;
    logic [FETCH_WIDTH*IMM_WIDTH-1:0]    out_imm;
    logic [FETCH_WIDTH*IMM_TYPE_WIDTH-1:0] out_imm_type;
    logic [FETCH_WIDTH-1:0]              out_illegal;

    modport master (
        output in_valid, in_lane_vld, in_instr, out_ready,
        input  in_ready, out_valid, out_lane_vld, out_imm, out_imm_type, out_illegal
    );

    modport slave (
        input  in_valid, in_lane_vld, in_instr, out_ready,
        output in_ready, out_valid, out_lane_vld, out_imm, out_imm_type, out_illegal
    );

endinterface

// File: rtl/imm_gen_pipe_imm_decode_lane.sv
// Combinational RV32I immediate decode for a single fetch lane.
module imm_decode_lane
    import imm_gen_pipe_pkg::*;
#(
    parameter int IMM_WIDTH    = DEF_IMM_WIDTH,
    parameter int OPCODE_WIDTH = DEF_OPCODE_WIDTH
) (
    input  logic [INSTR_WIDTH-1:0] instr_i,
    input  logic                   laneVld_i,
    output logic [IMM_WIDTH-1:0]   imm_o,
    output imm_type_t              immType_o,
    output logic                   illegal_o
);

    opcode_t opcode;
    assign opcode = opcode_t'(instr_i[OPCODE_WIDTH-1:0]);

    // Invalid lanes look like R-type so rename sees a zero immediate and no fault.
    always_comb begin
        imm_o     = '0;
        immType_o = IMM_R;
        illegal_o = 1'b0;
        if (laneVld_i) begin
            case (opcode)
                OP_OP: begin
                    immType_o = IMM_R;
                end
                OP_LOAD, OP_IMM, OP_JALR: begin
                    imm_o     = IMM_WIDTH'($signed(instr_i[31:20]));
                    immType_o = IMM_I;
                end
                OP_STORE: begin
                    imm_o     = IMM_WIDTH'($signed({instr_i[31:25], instr_i[11:7]}));
                    immType_o = IMM_S;
                end
                OP_BRANCH: begin
                    imm_o     = IMM_WIDTH'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                                    instr_i[11:8], 1'b0}));
                    immType_o = IMM_B;
                end
                OP_LUI, OP_AUIPC: begin
                    imm_o     = IMM_WIDTH'($signed({instr_i[31:12], 12'b0}));
                    immType_o = IMM_U;
                end
                OP_JAL: begin
                    imm_o     = IMM_WIDTH'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                                    instr_i[30:21], 1'b0}));
                    immType_o = IMM_J;
                end
                default: begin
                    immType_o = IMM_ILL;
                    illegal_o = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined multi-lane immediate generator: per-lane decode feeding an output
// register backed by a one-entry skid register so in_ready comes from a flop.
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int FETCH_WIDTH  = DEF_FETCH_WIDTH,
    parameter int IMM_WIDTH    = DEF_IMM_WIDTH,
    parameter int OPCODE_WIDTH = DEF_OPCODE_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    imm_gen_pipe_if.slave bus
);

    localparam int IW = FETCH_WIDTH * IMM_WIDTH;
    localparam int TW = FETCH_WIDTH * IMM_TYPE_WIDTH;

    if (IMM_WIDTH < 32) begin : gBadImmWidth
        $error("imm_gen_pipe: IMM_WIDTH must be at least 32");
    end

    logic [IW-1:0]          decImm;
    logic [TW-1:0]          decType;
    logic [FETCH_WIDTH-1:0] decIll;

    for (genvar g = 0; g < FETCH_WIDTH; g++) begin : gLane
        imm_type_t laneType;

        imm_decode_lane #(
            .IMM_WIDTH    (IMM_WIDTH),
            .OPCODE_WIDTH (OPCODE_WIDTH)
        ) uDecode (
            .instr_i   (bus.in_instr[g*INSTR_WIDTH +: INSTR_WIDTH]),
            .laneVld_i (bus.in_lane_vld[g]),
            .imm_o     (decImm[g*IMM_WIDTH +: IMM_WIDTH]),
            .immType_o (laneType),
            .illegal_o (decIll[g])
        );

        assign decType[g*IMM_TYPE_WIDTH +: IMM_TYPE_WIDTH] = laneType;
    end

    logic                   orValid_q,   orValid_d;
    logic [FETCH_WIDTH-1:0] orLaneVld_q, orLaneVld_d;
    logic [IW-1:0]          orImm_q,     orImm_d;
    logic [TW-1:0]          orType_q,    orType_d;
    logic [FETCH_WIDTH-1:0] orIll_q,     orIll_d;

    logic                   skValid_q,   skValid_d;
    logic [FETCH_WIDTH-1:0] skLaneVld_q, skLaneVld_d;
    logic [IW-1:0]          skImm_q,     skImm_d;
    logic [TW-1:0]          skType_q,    skType_d;
    logic [FETCH_WIDTH-1:0] skIll_q,     skIll_d;

    logic inReady_q;
    logic accept;
    logic orFree;

    assign accept = bus.in_valid & inReady_q;
    assign orFree = ~orValid_q | bus.out_ready;

    // The skid entry is always older than a new arrival, so it wins the output register.
    always_comb begin
        orValid_d   = orValid_q;
        orLaneVld_d = orLaneVld_q;
        orImm_d     = orImm_q;
        orType_d    = orType_q;
        orIll_d     = orIll_q;
        skValid_d   = skValid_q;
        skLaneVld_d = skLaneVld_q;
        skImm_d     = skImm_q;
        skType_d    = skType_q;
        skIll_d     = skIll_q;

        if (flush) begin
            orValid_d = 1'b0;
            skValid_d = 1'b0;
        end else if (orFree) begin
            if (skValid_q) begin
                orValid_d   = 1'b1;
                orLaneVld_d = skLaneVld_q;
                orImm_d     = skImm_q;
                orType_d    = skType_q;
                orIll_d     = skIll_q;
                skValid_d   = accept;
                if (accept) begin
                    skLaneVld_d = bus.in_lane_vld;
                    skImm_d     = decImm;
                    skType_d    = decType;
                    skIll_d     = decIll;
                end
            end else begin
                orValid_d = accept;
                if (accept) begin
                    orLaneVld_d = bus.in_lane_vld;
                    orImm_d     = decImm;
                    orType_d    = decType;
                    orIll_d     = decIll;
                end
            end
        end else if (accept) begin
            skValid_d   = 1'b1;
            skLaneVld_d = bus.in_lane_vld;
            skImm_d     = decImm;
            skType_d    = decType;
            skIll_d     = decIll;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            orValid_q   <= 1'b0;
            orLaneVld_q <= '0;
            orImm_q     <= '0;
            orType_q    <= '0;
            orIll_q     <= '0;
            skValid_q   <= 1'b0;
            skLaneVld_q <= '0;
            skImm_q     <= '0;
            skType_q    <= '0;
            skIll_q     <= '0;
            inReady_q   <= 1'b1;
        end else begin
            orValid_q   <= orValid_d;
            orLaneVld_q <= orLaneVld_d;
            orImm_q     <= orImm_d;
            orType_q    <= orType_d;
            orIll_q     <= orIll_d;
            skValid_q   <= skValid_d;
            skLaneVld_q <= skLaneVld_d;
            skImm_q     <= skImm_d;
            skType_q    <= skType_d;
            skIll_q     <= skIll_d;
            inReady_q   <= ~skValid_d;
        end
    end

    assign bus.in_ready     = inReady_q;
    assign bus.out_valid    = orValid_q;
    assign bus.out_lane_vld = orLaneVld_q;
    assign bus.out_imm      = orImm_q;
    assign bus.out_imm_type = orType_q;
    assign bus.out_illegal  = orIll_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe with hand-computed immediates.
module tb_imm_gen_pipe;
    import imm_gen_pipe_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.FETCH_WIDTH(2), .IMM_WIDTH(32)) bus ();

    imm_gen_pipe #(
        .FETCH_WIDTH  (2),
        .IMM_WIDTH    (32),
        .OPCODE_WIDTH (7)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic vld, input logic [1:0] laneVld,
                                 input logic [31:0] i0, input logic [31:0] i1);
        bus.in_valid    = vld;
        bus.in_lane_vld = laneVld;
        bus.in_instr    = {i1, i0};
    endtask

    task automatic checkOutput(input string tag, input logic expValid, input logic [1:0] expLane,
                               input logic [31:0] e0, input logic [31:0] e1,
                               input imm_type_t t0, input imm_type_t t1,
                               input logic [1:0] expIll);
        chk({tag, ".valid"}, 64'(bus.out_valid), 64'(expValid));
        if (expValid) begin
            chk({tag, ".lane"}, 64'(bus.out_lane_vld), 64'(expLane));
            chk({tag, ".imm"},  64'(bus.out_imm), {e1, e0});
            chk({tag, ".type"}, 64'(bus.out_imm_type), 64'({t1, t0}));
            chk({tag, ".ill"},  64'(bus.out_illegal), 64'(expIll));
        end
    endtask

    task automatic checkReady(input string tag, input logic exp);
        chk({tag, ".ready"}, 64'(bus.in_ready), 64'(exp));
    endtask

    task automatic checkResetState(input string tag);
        chk({tag, ".valid"}, 64'(bus.out_valid), 64'(0));
        chk({tag, ".ready"}, 64'(bus.in_ready), 64'(1));
        chk({tag, ".lane"},  64'(bus.out_lane_vld), 64'(0));
        chk({tag, ".imm"},   64'(bus.out_imm), 64'(0));
        chk({tag, ".type"},  64'(bus.out_imm_type), 64'(0));
        chk({tag, ".ill"},   64'(bus.out_illegal), 64'(0));
    endtask

    function automatic logic [31:0] addiK(input int k);
        return {12'(k), 20'h00093};
    endfunction

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b1;
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
        repeat (2) tick();
        checkResetState("reset");
        reset = 1'b0;

        // Format coverage with the consumer always ready.
        applyStimulus(1'b1, 2'b11, 32'hFFF00093, 32'h00112623);
        tick();
        checkOutput("addi_sw", 1'b1, 2'b11, 32'hFFFFFFFF, 32'h0000000C, IMM_I, IMM_S, 2'b00);

        applyStimulus(1'b1, 2'b11, 32'hFE000EE3, 32'h001000EF);
        tick();
        checkOutput("beq_jal", 1'b1, 2'b11, 32'hFFFFFFFC, 32'h00000800, IMM_B, IMM_J, 2'b00);

        applyStimulus(1'b1, 2'b11, 32'h123450B7, 32'h0000007F);
        tick();
        checkOutput("lui_ill", 1'b1, 2'b11, 32'h12345000, 32'h00000000, IMM_U, IMM_ILL, 2'b10);

        applyStimulus(1'b1, 2'b10, 32'h0000007F, 32'h80002003);
        tick();
        checkOutput("inv_lw", 1'b1, 2'b10, 32'h00000000, 32'hFFFFF800, IMM_R, IMM_I, 2'b00);

        applyStimulus(1'b1, 2'b11, 32'hFFFFF097, 32'hFFC080E7);
        tick();
        checkOutput("auipc_jalr", 1'b1, 2'b11, 32'hFFFFF000, 32'hFFFFFFFC, IMM_U, IMM_I, 2'b00);

        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
        tick();
        checkOutput("drain", 1'b0, 2'b00, 32'h0, 32'h0, IMM_R, IMM_R, 2'b00);

        // Back-pressure: two bundles fit, the third waits until the skid drains.
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, 2'b01, addiK(1), 32'h0);
        checkReady("bp.c1", 1'b1);
        tick();
        checkOutput("bp.c2", 1'b1, 2'b01, 32'd1, 32'd0, IMM_I, IMM_R, 2'b00);
        checkReady("bp.c2", 1'b1);
        applyStimulus(1'b1, 2'b01, addiK(2), 32'h0);
        tick();
        checkOutput("bp.c3", 1'b1, 2'b01, 32'd1, 32'd0, IMM_I, IMM_R, 2'b00);
        checkReady("bp.c3", 1'b0);
        applyStimulus(1'b1, 2'b01, addiK(3), 32'h0);
        tick();
        checkOutput("bp.hold", 1'b1, 2'b01, 32'd1, 32'd0, IMM_I, IMM_R, 2'b00);
        checkReady("bp.hold", 1'b0);
        bus.out_ready = 1'b1;
        tick();
        checkOutput("bp.out2", 1'b1, 2'b01, 32'd2, 32'd0, IMM_I, IMM_R, 2'b00);
        checkReady("bp.out2", 1'b1);
        tick();
        checkOutput("bp.out3", 1'b1, 2'b01, 32'd3, 32'd0, IMM_I, IMM_R, 2'b00);
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
        tick();
        checkOutput("bp.empty", 1'b0, 2'b00, 32'h0, 32'h0, IMM_R, IMM_R, 2'b00);

        // Flush with both registers full.
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, 2'b01, addiK(10), 32'h0);
        tick();
        applyStimulus(1'b1, 2'b01, addiK(11), 32'h0);
        tick();
        checkReady("fl.full", 1'b0);
        flush = 1'b1;
        applyStimulus(1'b1, 2'b01, addiK(12), 32'h0);
        tick();
        flush = 1'b0;
        checkOutput("fl.full", 1'b0, 2'b00, 32'h0, 32'h0, IMM_R, IMM_R, 2'b00);
        checkReady("fl.after", 1'b1);

        // Flush while a bundle is actually accepted in the same cycle.
        applyStimulus(1'b1, 2'b01, addiK(13), 32'h0);
        tick();
        flush = 1'b1;
        applyStimulus(1'b1, 2'b01, addiK(14), 32'h0);
        tick();
        flush = 1'b0;
        bus.out_ready = 1'b1;
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
        checkOutput("fl.acc", 1'b0, 2'b00, 32'h0, 32'h0, IMM_R, IMM_R, 2'b00);
        checkReady("fl.acc", 1'b1);
        tick();
        checkOutput("fl.gone", 1'b0, 2'b00, 32'h0, 32'h0, IMM_R, IMM_R, 2'b00);

        // Reset mid-stall, then a fresh R-type bundle.
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, 2'b01, addiK(20), 32'h0);
        tick();
        applyStimulus(1'b1, 2'b01, addiK(21), 32'h0);
        tick();
        reset = 1'b1;
        applyStimulus(1'b1, 2'b01, addiK(22), 32'h0);
        tick();
        reset = 1'b0;
        checkResetState("rst.mid");
        bus.out_ready = 1'b1;
        applyStimulus(1'b1, 2'b11, 32'h002081B3, 32'h40B50533);
        tick();
        checkOutput("rst.rtype", 1'b1, 2'b11, 32'h0, 32'h0, IMM_R, IMM_R, 2'b00);
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
        tick();
        checkOutput("rst.empty", 1'b0, 2'b00, 32'h0, 32'h0, IMM_R, IMM_R, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
